// File: rtl/dma_axis_chan_arbiter.sv
// Packet round-robin merge of NUM_CHAN AXI4-Stream channels into one registered output.
// Latency is 1 cycle per beat. Input ready follows the output skid rule, and there is one arbitration cycle per packet.
module dma_axis_chan_arbiter #(
   parameter int NUM_CHAN    = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int TUSER_WIDTH = 128,
   parameter int TAG_EN      = 1,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                              bkd_clk,
   input  logic                              bkd_rst,
   input  logic [NUM_CHAN-1:0]               chan_en,
   input  logic [NUM_CHAN*DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [NUM_CHAN*DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [NUM_CHAN*TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic [NUM_CHAN-1:0]               s_axis_tvalid,
   input  logic [NUM_CHAN-1:0]               s_axis_tlast,
   output logic [NUM_CHAN-1:0]               s_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]           m_axis_tstrb,
   output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [NUM_CHAN*CNT_WIDTH-1:0]     chan_pkt_cnt
);
   localparam int            GW      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
   localparam int            SW      = DATA_WIDTH / 8;
   localparam logic [GW:0]   NCH_W   = (GW+1)'(NUM_CHAN);
   localparam logic [GW-1:0] LAST_CH = GW'(NUM_CHAN - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t                  r_state, w_state_nxt;
   logic [GW-1:0]           r_grant, r_rr_ptr;
   logic [GW-1:0]           w_pick, w_rr_nxt;
   logic [GW:0]             w_sum;
   logic                    w_found;
   logic [NUM_CHAN-1:0]     w_req;
   logic [2*NUM_CHAN-1:0]   w_req_rot;
   logic                    w_in_rdy, w_load, w_load_last;
   int                      w_gidx;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic [SW-1:0]           w_sel_strb;
   logic [TUSER_WIDTH-1:0]  w_sel_user;

   logic [DATA_WIDTH-1:0]   r_tdata;
   logic [SW-1:0]           r_tstrb;
   logic [TUSER_WIDTH-1:0]  r_tuser;
   logic                    r_tvalid, r_tlast;
   logic [CNT_WIDTH-1:0]    r_cnt [NUM_CHAN];

   // Rotate the request vector so bit 0 is the channel at rr_ptr; the first set bit wins.
   always_comb begin
      w_req     = s_axis_tvalid & chan_en;
      w_req_rot = {w_req, w_req} >> r_rr_ptr;
      w_found   = 1'b0;
      w_pick    = r_rr_ptr;
      w_sum     = '0;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (!w_found && w_req_rot[k]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_rr_ptr} + (GW+1)'(k);
            if (w_sum >= NCH_W) begin
               w_sum = w_sum - NCH_W;
            end
            w_pick  = w_sum[GW-1:0];
         end
      end
      w_rr_nxt = (w_pick == LAST_CH) ? '0 : w_pick + GW'(1);
   end

   always_comb begin
      w_gidx     = int'(r_grant);
      w_sel_data = s_axis_tdata[w_gidx*DATA_WIDTH +: DATA_WIDTH];
      w_sel_strb = s_axis_tstrb[w_gidx*SW +: SW];
      w_sel_user = s_axis_tuser[w_gidx*TUSER_WIDTH +: TUSER_WIDTH];
      if (TAG_EN != 0) begin
         w_sel_user[31:24] = 8'(r_grant);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_in_rdy      = 1'b0;
      w_load        = 1'b0;
      w_load_last   = 1'b0;
      s_axis_tready = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_in_rdy               = ~r_tvalid | m_axis_tready;
            s_axis_tready[r_grant] = w_in_rdy;
            w_load                 = w_in_rdy & s_axis_tvalid[r_grant];
            w_load_last            = w_load & s_axis_tlast[r_grant];
            if (w_load_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge bkd_clk) begin
      if (bkd_rst) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_tdata  <= '0;
         r_tstrb  <= '0;
         r_tuser  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         for (int i = 0; i < NUM_CHAN; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_found) begin
            r_grant  <= w_pick;
            r_rr_ptr <= w_rr_nxt;
         end
         if (w_load) begin
            r_tdata  <= w_sel_data;
            r_tstrb  <= w_sel_strb;
            r_tuser  <= w_sel_user;
            r_tlast  <= s_axis_tlast[r_grant];
            r_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
         end
         if (w_load_last) begin
            r_cnt[r_grant] <= r_cnt[r_grant] + CNT_WIDTH'(1);
         end
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tstrb  = r_tstrb;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;

   for (genvar g = 0; g < NUM_CHAN; g++) begin : g_cnt
      assign chan_pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
   end
endmodule

// File: tb/tb_dma_axis_chan_arbiter.sv
// Directed bench for dma_axis_chan_arbiter: per-channel beat sources, a beat scoreboard and grant-order log.
module tb_dma_axis_chan_arbiter;
   localparam int NCH = 4, DW = 64, SW = 8, TUW = 128, CW = 4, DEPTH = 64;

   logic                 bkd_clk = 1'b0;
   logic                 bkd_rst = 1'b1;
   logic [NCH-1:0]       chan_en = '1;
   logic [NCH*DW-1:0]    s_axis_tdata = '0;
   logic [NCH*SW-1:0]    s_axis_tstrb = '0;
   logic [NCH*TUW-1:0]   s_axis_tuser = '0;
   logic [NCH-1:0]       s_axis_tvalid = '0;
   logic [NCH-1:0]       s_axis_tlast = '0;
   logic [NCH-1:0]       s_axis_tready;
   logic [DW-1:0]        m_axis_tdata;
   logic [SW-1:0]        m_axis_tstrb;
   logic [TUW-1:0]       m_axis_tuser;
   logic                 m_axis_tvalid;
   logic                 m_axis_tlast;
   logic                 m_axis_tready = 1'b1;
   logic [NCH*CW-1:0]    chan_pkt_cnt;

   always #5 bkd_clk = ~bkd_clk;

   dma_axis_chan_arbiter #(
      .NUM_CHAN(NCH), .DATA_WIDTH(DW), .TUSER_WIDTH(TUW), .TAG_EN(1), .CNT_WIDTH(CW)
   ) u_dut (
      .bkd_clk(bkd_clk), .bkd_rst(bkd_rst), .chan_en(chan_en),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .chan_pkt_cnt(chan_pkt_cnt)
   );

   int checks = 0;
   int failures = 0;

   logic [72:0]  mem [NCH][DEPTH];   // {last, strb, data}
   int           wr [NCH];
   int           rd [NCH];
   logic         hold [NCH];
   logic         sop [NCH];
   logic [200:0] sbq [$];            // {user, data, strb, last}
   int           order [64];
   int           n_order;
   int           n_in;
   int           cyc;
   int           last_end;
   logic         gap_chk;
   logic [NCH-1:0] in_fire;
   logic         out_fire, p_vld, p_rdy, p_rst;
   logic [200:0] p_out;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TUW-1:0] in_user(input int c);
      logic [TUW-1:0] u;
      u = {32'hC0DE_0000, 32'h1111_1111, 32'h2222_2222, 32'hF05A_3C00};
      u[7:0] = 8'(c);
      return u;
   endfunction

   function automatic logic [TUW-1:0] exp_user(input int c);
      logic [TUW-1:0] u;
      u = in_user(c);
      u[31:24] = 8'(c);
      return u;
   endfunction

   function automatic logic [200:0] out_word();
      return {m_axis_tuser, m_axis_tdata, m_axis_tstrb, m_axis_tlast};
   endfunction

   function automatic int cnt(input int c);
      return int'(chan_pkt_cnt[c*CW +: CW]);
   endfunction

   task automatic push_pkt(input int c, input logic [63:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[c][wr[c]] = {(i == n-1), ((i == 1) ? 8'h00 : 8'hFF), base + 64'(i)};
         wr[c]++;
      end
   endtask

   task automatic drive_heads();
      for (int c = 0; c < NCH; c++) begin
         logic [72:0] b;
         b = (rd[c] < wr[c]) ? mem[c][rd[c]] : '0;
         s_axis_tvalid[c]           = (rd[c] < wr[c]) && !hold[c];
         s_axis_tdata[c*DW +: DW]   = b[63:0];
         s_axis_tstrb[c*SW +: SW]   = b[71:64];
         s_axis_tlast[c]            = b[72];
         s_axis_tuser[c*TUW +: TUW] = in_user(c);
      end
   endtask

   // One clock: sample handshakes before the edge, then account and check after it.
   task automatic step();
      logic         loaded;
      logic [200:0] lw, e;
      logic [72:0]  b;
      drive_heads();
      #1;
      p_rst    = bkd_rst;
      in_fire  = bkd_rst ? '0 : (s_axis_tvalid & s_axis_tready);
      out_fire = !bkd_rst && m_axis_tvalid && m_axis_tready;
      p_vld    = m_axis_tvalid;
      p_rdy    = m_axis_tready;
      p_out    = out_word();
      if (!bkd_rst) chk("tready_onehot0", 256'($onehot0(s_axis_tready)), 1);
      @(negedge bkd_clk);
      cyc++;
      if (p_rst) begin
         chk("rst_m_tvalid", m_axis_tvalid, 0);
         chk("rst_s_tready", s_axis_tready, 0);
      end else begin
         if (out_fire) begin
            chk("sb_nonempty", (sbq.size() != 0), 1);
            if (sbq.size() != 0) chk("sb_out_beat", p_out, sbq.pop_front());
         end
         loaded = 1'b0;
         lw = '0;
         for (int c = 0; c < NCH; c++) begin
            if (in_fire[c]) begin
               b = mem[c][rd[c]];
               rd[c]++;
               n_in++;
               e = {exp_user(c), b[63:0], b[71:64], b[72]};
               sbq.push_back(e);
               lw = e;
               loaded = 1'b1;
               if (sop[c]) begin
                  order[n_order] = c;
                  n_order++;
                  if (gap_chk && last_end >= 0) chk("pkt_gap", cyc - last_end, 2);
               end
               if (b[72]) last_end = cyc;
               sop[c] = b[72];
            end
         end
         if (loaded) begin
            chk("load_vld", m_axis_tvalid, 1);
            chk("load_beat", out_word(), lw);
         end else begin
            chk("hold_vld", m_axis_tvalid, p_vld & ~p_rdy);
            if (p_vld && !p_rdy) chk("hold_beat", out_word(), p_out);
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      bkd_rst = 1'b1;
      m_axis_tready = 1'b1;
      chan_en = '1;
      for (int c = 0; c < NCH; c++) begin
         wr[c] = 0; rd[c] = 0; hold[c] = 1'b0; sop[c] = 1'b1;
      end
      sbq.delete();
      n_order = 0;
      last_end = -1;
      gap_chk = 1'b0;
      step();
      step();
      bkd_rst = 1'b0;
   endtask

   task automatic check_cnt(input string tag, input int e0, input int e1, input int e2, input int e3);
      chk({tag, "_cnt0"}, cnt(0), e0);
      chk({tag, "_cnt1"}, cnt(1), e1);
      chk({tag, "_cnt2"}, cnt(2), e2);
      chk({tag, "_cnt3"}, cnt(3), e3);
   endtask

   // seq holds the expected channel of packet i in nibble i.
   task automatic check_order(input string tag, input logic [63:0] seq, input int n);
      chk({tag, "_norder"}, n_order, n);
      for (int i = 0; i < n && i < n_order; i++) chk({tag, "_grant"}, order[i], int'(seq[4*i +: 4]));
   endtask

   initial begin
      int nb;
      n_in = 0;
      cyc = 0;

      do_reset();
      check_cnt("reset", 0, 0, 0, 0);
      chk("reset_tlast", m_axis_tlast, 0);
      chk("reset_tdata", m_axis_tdata, 0);

      // Single channel, tagged tuser, zero-strobe middle beat.
      do_reset();
      push_pkt(2, 64'hA0, 3);
      run(10);
      check_order("single", 64'h2, 1);
      check_cnt("single", 0, 0, 1, 0);
      chk("single_drained", rd[2], 3);

      // All channels requesting: strict rotation with one idle cycle per packet.
      do_reset();
      gap_chk = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         push_pkt(c, 64'h1000 * 64'(c + 1), 2);
         push_pkt(c, 64'h1000 * 64'(c + 1) + 64'h10, 2);
      end
      run(40);
      check_order("rr", 64'h3210_3210, 8);
      check_cnt("rr", 2, 2, 2, 2);

      // Input stall drains the output, then a 5-cycle downstream stall admits exactly one beat.
      do_reset();
      push_pkt(0, 64'h3000, 6);
      run(3);
      hold[0] = 1'b1;
      push_pkt(3, 64'h3300, 2);
      run(2);
      hold[0] = 1'b0;
      m_axis_tready = 1'b0;
      nb = n_in;
      run(5);
      chk("bp_accepted", n_in - nb, 1);
      m_axis_tready = 1'b1;
      run(20);
      check_order("bp", 64'h30, 2);
      check_cnt("bp", 1, 0, 0, 1);
      chk("bp_drained", rd[0], 6);

      // Enable mask, with ch1 disabled part-way through its first packet.
      do_reset();
      chan_en = 4'b1011;
      push_pkt(0, 64'h4000, 2);
      push_pkt(1, 64'h4100, 4);
      push_pkt(1, 64'h4200, 4);
      push_pkt(2, 64'h4300, 2);
      push_pkt(3, 64'h4400, 2);
      for (int i = 0; i < 40; i++) begin
         step();
         if (rd[1] == 2) chan_en = 4'b1001;
      end
      check_order("en", 64'h310, 3);
      check_cnt("en", 1, 1, 0, 1);
      chk("en_ch1_rd", rd[1], 4);
      chk("en_ch2_rd", rd[2], 0);

      // Reset during beat 2 of a 4-beat packet.
      do_reset();
      push_pkt(0, 64'h5000, 2);
      push_pkt(1, 64'h5100, 4);
      for (int i = 0; i < 20; i++) if (rd[1] < 1) step();
      chk("mrst_reached", rd[1], 1);
      chk("mrst_pre_cnt0", cnt(0), 1);
      bkd_rst = 1'b1;
      step();
      bkd_rst = 1'b0;
      check_cnt("mrst", 0, 0, 0, 0);
      rd[1] = wr[1];
      sop[1] = 1'b1;
      sbq.delete();
      n_order = 0;
      push_pkt(1, 64'h5200, 2);
      push_pkt(0, 64'h5300, 2);
      run(20);
      check_order("mrst", 64'h10, 2);
      check_cnt("mrst_after", 1, 1, 0, 0);

      // 4-bit counter wraps after 16 packets.
      do_reset();
      gap_chk = 1'b1;
      for (int i = 0; i < 17; i++) push_pkt(0, 64'h6000 + 64'(i), 1);
      run(50);
      chk("wrap_drained", rd[0], 17);
      chk("wrap_norder", n_order, 17);
      chk("wrap_cnt0", cnt(0), 1);
      chk("wrap_sb_empty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
